// File: rtl/rfdc_init_sequencer.sv
// RFDC bring-up sequencer: walks an external entry table and replays it as Wishbone master cycles.
// Latency: FETCH+DECODE per entry, one outstanding bus cycle, POLL_GAP idle cycles between poll reads.
// Backpressure: each bus cycle is held until m_ack_i or the ack timeout; the table is read only when needed.
//
// Entry format {op[1:0], addr[17:0], data[31:0], mask[31:0]}; ops WRITE, POLL, DELAY, END.
// Errors (poll timeout, ack timeout, bridge error, abort) stop the run and record the failing index.
module rfdc_init_sequencer #(
  parameter int NENTRY    = 64,
  parameter int ADDR_BITS = 18,
  parameter int TMO_BITS  = 20,
  parameter int POLL_GAP  = 16,
  localparam int IDX_W    = $clog2(NENTRY)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o,
  output logic [IDX_W-1:0]     err_index_o,
  output logic [IDX_W-1:0]     tbl_addr_o,
  input  logic [83:0]          tbl_data_i,
  output logic                 m_cyc_o,
  output logic                 m_stb_o,
  output logic                 m_we_o,
  output logic [ADDR_BITS-1:0] m_adr_o,
  output logic [31:0]          m_dat_o,
  output logic [3:0]           m_sel_o,
  input  logic [31:0]          m_dat_i,
  input  logic                 m_ack_i,
  input  logic                 bridge_err_i
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_BUS    = 4'd3;
  localparam logic [3:0] S_GAP    = 4'd4;
  localparam logic [3:0] S_DLY    = 4'd5;
  localparam logic [3:0] S_NEXT   = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd1;
  localparam logic [1:0] OP_DELAY = 2'd2;
  localparam logic [1:0] OP_END   = 2'd3;

  localparam logic [1:0] EC_POLL = 2'd1;
  localparam logic [1:0] EC_ACK  = 2'd2;
  localparam logic [1:0] EC_BUS  = 2'd3;

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [TMO_BITS-1:0] TMO_MAX  = '1;
  localparam logic [TMO_BITS-1:0] ACK_LAST = TMO_MAX - TMO_BITS'(1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NENTRY - 1);
  localparam logic [GAP_W-1:0]    GAP_LOAD = GAP_W'(POLL_GAP - 1);

  logic [3:0]          state;
  logic [IDX_W-1:0]    idx;
  logic [1:0]          ent_op;
  logic [17:0]         ent_addr;
  logic [31:0]         ent_data;
  logic [31:0]         ent_mask;
  logic [TMO_BITS-1:0] ack_cnt;
  logic [TMO_BITS-1:0] poll_cnt;
  logic [TMO_BITS-1:0] dly_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [1:0]          ecode;
  logic                pend_err;

  logic err_req;
  logic poll_match;
  logic poll_exp;

  // abort/bridge error seen now or earlier in this run; a bus cycle in flight finishes first
  assign err_req    = pend_err | abort_i | bridge_err_i;
  assign poll_match = ((m_dat_i ^ ent_data) & ent_mask) == 32'd0;
  assign poll_exp   = (poll_cnt == TMO_MAX);

  assign busy_o     = (state != S_IDLE);
  assign tbl_addr_o = idx;
  assign m_cyc_o    = (state == S_BUS);
  assign m_stb_o    = (state == S_BUS);
  assign m_we_o     = (state == S_BUS) && (ent_op == OP_WRITE);
  assign m_adr_o    = ADDR_BITS'(ent_addr);
  assign m_dat_o    = ent_data;
  assign m_sel_o    = 4'hF;

  // sequencer state machine, counters and sticky status
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      idx         <= '0;
      ent_op      <= OP_WRITE;
      ent_addr    <= '0;
      ent_data    <= '0;
      ent_mask    <= '0;
      ack_cnt     <= '0;
      poll_cnt    <= '0;
      dly_cnt     <= '0;
      gap_cnt     <= '0;
      ecode       <= '0;
      pend_err    <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= '0;
      err_index_o <= '0;
    end else begin
      if (state == S_IDLE) begin
        pend_err <= 1'b0;
      end else if (abort_i || bridge_err_i) begin
        pend_err <= 1'b1;
      end

      // the poll timeout budget spans every read and gap of one POLL entry
      if ((state == S_BUS || state == S_GAP) && ent_op == OP_POLL && !poll_exp) begin
        poll_cnt <= poll_cnt + TMO_BITS'(1);
      end

      case (state)
        S_IDLE: begin
          if (start_i) begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            idx    <= '0;
            state  <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (err_req) begin
            ecode <= EC_BUS;
            state <= S_ERR;
          end else begin
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (err_req) begin
            ecode <= EC_BUS;
            state <= S_ERR;
          end else begin
            ent_op   <= tbl_data_i[83:82];
            ent_addr <= tbl_data_i[81:64];
            ent_data <= tbl_data_i[63:32];
            ent_mask <= tbl_data_i[31:0];
            case (tbl_data_i[83:82])
              OP_WRITE, OP_POLL: begin
                ack_cnt  <= '0;
                poll_cnt <= '0;
                state    <= S_BUS;
              end
              OP_DELAY: begin
                dly_cnt <= tbl_data_i[32 +: TMO_BITS];
                state   <= (tbl_data_i[32 +: TMO_BITS] == '0) ? S_NEXT : S_DLY;
              end
              default: state <= S_DONE;
            endcase
          end
        end

        S_BUS: begin
          if (m_ack_i) begin
            if (err_req) begin
              ecode <= EC_BUS;
              state <= S_ERR;
            end else if (ent_op == OP_WRITE || poll_match) begin
              state <= S_NEXT;
            end else if (poll_exp) begin
              ecode <= EC_POLL;
              state <= S_ERR;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
            end
          end else if (ack_cnt == ACK_LAST) begin
            ecode <= EC_ACK;
            state <= S_ERR;
          end else begin
            ack_cnt <= ack_cnt + TMO_BITS'(1);
          end
        end

        S_GAP: begin
          if (err_req) begin
            ecode <= EC_BUS;
            state <= S_ERR;
          end else if (poll_exp) begin
            ecode <= EC_POLL;
            state <= S_ERR;
          end else if (gap_cnt == '0) begin
            ack_cnt <= '0;
            state   <= S_BUS;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        S_DLY: begin
          if (err_req) begin
            ecode <= EC_BUS;
            state <= S_ERR;
          end else if (dly_cnt == TMO_BITS'(1)) begin
            state <= S_NEXT;
          end else begin
            dly_cnt <= dly_cnt - TMO_BITS'(1);
          end
        end

        S_NEXT: begin
          if (err_req) begin
            ecode <= EC_BUS;
            state <= S_ERR;
          end else if (idx == IDX_LAST) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= S_FETCH;
          end
        end

        S_DONE: begin
          done_o <= 1'b1;
          state  <= S_IDLE;
        end

        S_ERR: begin
          err_o       <= 1'b1;
          err_code_o  <= ecode;
          err_index_o <= idx;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rfdc_init_sequencer.sv
// Bench for rfdc_init_sequencer: directed bring-up scenarios plus random tables.
// Latency: expected bus traffic and outcome come from a table-walking model.
// Backpressure: a Wishbone slave with random or fixed ack latency, optional never-ack address.
module tb_rfdc_init_sequencer;

  localparam int NENTRY    = 16;
  localparam int ADDR_BITS = 18;
  localparam int TMO_BITS  = 8;
  localparam int POLL_GAP  = 5;
  localparam int IDX_W     = 4;

  localparam logic [1:0]  OP_WR = 2'd0, OP_POLL = 2'd1, OP_DLY = 2'd2, OP_END = 2'd3;
  localparam logic [17:0] NOACK = 18'h3FFFF;

  typedef struct {
    logic [1:0]  op;
    logic [17:0] adr;
    logic [31:0] dat;
    logic [31:0] msk;
    int          nmiss;
    bit          never;
  } ent_t;

  typedef struct {
    bit          we;
    logic [17:0] adr;
    logic [31:0] dat;
  } txn_t;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i, start_i, abort_i;
  logic busy_o, done_o, err_o;
  logic [1:0] err_code_o;
  logic [IDX_W-1:0] err_index_o, tbl_addr_o;
  logic [83:0] tbl_data_i;
  logic m_cyc_o, m_stb_o, m_we_o;
  logic [ADDR_BITS-1:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0] m_sel_o;
  logic [31:0] m_dat_i;
  logic m_ack_i, bridge_err_i;

  rfdc_init_sequencer #(
    .NENTRY(NENTRY), .ADDR_BITS(ADDR_BITS), .TMO_BITS(TMO_BITS), .POLL_GAP(POLL_GAP)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
    .err_index_o(err_index_o), .tbl_addr_o(tbl_addr_o), .tbl_data_i(tbl_data_i),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .bridge_err_i(bridge_err_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  ent_t        tbl [NENTRY];
  txn_t        exp_q[$];
  logic [31:0] rsp_q[$];
  int          rd_cyc_q[$];

  int total = 0, bad = 0;
  string cur_test = "init";

  // scenario knobs
  bit noack_on = 0;
  int berr_txn = -1;
  int lat_fix = -1;
  int abort_at = -1;
  bit tail_vld = 0;
  logic [17:0] tail_adr;
  logic [31:0] mis_default = '0;

  // model results
  bit e_done, e_err, e_busy_vld;
  int e_code, e_idx, e_busy, n_exp;

  // slave/run observations
  int ncyc = 0, cyc_total = 0, cyc_run = 0, last_run = 0, last_ack_cyc = 0;
  int obs_cnt = 0, busy_n = 0, idle_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s/%s got=%0h exp=%0h", cur_test, tag, got, exp);
    end
  endtask

  function automatic logic [83:0] pack(input ent_t e);
    return {e.op, e.adr, e.dat, e.msk};
  endfunction

  task automatic set_ent(input int i, input logic [1:0] op, input logic [17:0] adr,
                         input logic [31:0] dat, input logic [31:0] msk, input int nmiss, input bit never);
    tbl[i] = '{op, adr, dat, msk, nmiss, never};
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < NENTRY; i++) set_ent(i, OP_END, 18'h0, 32'h0, 32'h0, 0, 0);
  endtask

  // Walk the table the way software would describe it: each entry's effect on the bus and the outcome.
  task automatic model_run();
    int t;
    logic [31:0] r;
    exp_q.delete(); rsp_q.delete();
    e_done = 0; e_err = 0; e_code = 0; e_idx = 0; tail_vld = 0;
    e_busy = 0; e_busy_vld = 1; t = 0;
    for (int i = 0; i < NENTRY; i++) begin
      e_busy += 2;
      case (tbl[i].op)
        OP_WR: begin
          e_busy_vld = 0;
          if (noack_on && tbl[i].adr == NOACK) begin
            e_err = 1; e_code = 2; e_idx = i; n_exp = exp_q.size(); return;
          end
          exp_q.push_back('{1'b1, tbl[i].adr, tbl[i].dat});
          if (t == berr_txn) begin e_err = 1; e_code = 3; e_idx = i; n_exp = exp_q.size(); return; end
          t++;
        end
        OP_POLL: begin
          e_busy_vld = 0;
          if (tbl[i].never) begin
            r = $urandom;
            mis_default = ((tbl[i].dat ^ 32'h1) & tbl[i].msk) | (r & ~tbl[i].msk);
            tail_vld = 1; tail_adr = tbl[i].adr;
            e_err = 1; e_code = 1; e_idx = i; n_exp = exp_q.size(); return;
          end
          for (int k = 0; k <= tbl[i].nmiss; k++) begin
            r = $urandom;
            if (k < tbl[i].nmiss) rsp_q.push_back(((tbl[i].dat ^ 32'h1) & tbl[i].msk) | (r & ~tbl[i].msk));
            else                  rsp_q.push_back((tbl[i].dat & tbl[i].msk) | (r & ~tbl[i].msk));
            exp_q.push_back('{1'b0, tbl[i].adr, 32'h0});
            if (t == berr_txn) begin e_err = 1; e_code = 3; e_idx = i; n_exp = exp_q.size(); return; end
            t++;
          end
        end
        OP_DLY: e_busy += int'(tbl[i].dat[TMO_BITS-1:0]) + 1;
        default: begin e_busy += 1; e_done = 1; n_exp = exp_q.size(); return; end
      endcase
    end
    e_busy += 1;
    e_done = 1;
    n_exp = exp_q.size();
  endtask

  // Wishbone slave and one-cycle-latency table memory, both acting at the falling edge
  initial begin
    logic [IDX_W-1:0] prev_a;
    int wcnt, lat;
    bit in_cyc;
    txn_t e;
    m_ack_i = 0; m_dat_i = 0; bridge_err_i = 0; tbl_data_i = '0;
    prev_a = '0; wcnt = 0; lat = 0; in_cyc = 0;
    forever begin
      @(negedge wb_clk_i);
      ncyc++;
      tbl_data_i = pack(tbl[prev_a]);
      prev_a = tbl_addr_o;
      bridge_err_i = 1'b0;
      if (m_cyc_o) begin
        cyc_total++; cyc_run++;
      end else begin
        if (cyc_run != 0) last_run = cyc_run;
        cyc_run = 0;
      end
      if (m_ack_i) begin
        m_ack_i = 1'b0;
      end else if (m_cyc_o && m_stb_o) begin
        if (!in_cyc) begin
          in_cyc = 1; wcnt = 0;
          lat = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 3);
        end
        if (!(noack_on && m_we_o && m_adr_o == NOACK)) begin
          if (wcnt >= lat) begin
            m_ack_i = 1'b1;
            last_ack_cyc = ncyc;
            if (m_we_o) begin
              m_dat_i = $urandom;
            end else begin
              if (rsp_q.size() != 0) m_dat_i = rsp_q.pop_front();
              else                   m_dat_i = mis_default;
              rd_cyc_q.push_back(ncyc);
            end
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("we", m_we_o, e.we);
              chk("adr", m_adr_o, e.adr);
              if (e.we) chk("wdat", m_dat_o, e.dat);
            end else if (tail_vld) begin
              chk("tail_rd", {m_we_o, m_adr_o}, {1'b0, tail_adr});
            end
            chk("sel", m_sel_o, 4'hF);
            if (obs_cnt == berr_txn) bridge_err_i = 1'b1;
            obs_cnt++;
          end else begin
            wcnt++;
          end
        end
      end
      if (!m_cyc_o) in_cyc = 0;
    end
  end

  task automatic do_reset();
    @(negedge wb_clk_i); wb_rst_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    #1;
  endtask

  // Start the table, wait (bounded) for idle, then compare the outcome with the model.
  task automatic run_seq(input int lim);
    int n, snap;
    obs_cnt = 0; rd_cyc_q.delete();
    @(negedge wb_clk_i); start_i = 1'b1;
    @(negedge wb_clk_i); start_i = 1'b0; #1;
    chk("start_clr_done", done_o, 1'b0);
    chk("start_clr_err", err_o, 1'b0);
    n = 0;
    while (busy_o && n < lim) begin
      n++;
      abort_i = (n == abort_at);
      @(negedge wb_clk_i); #1;
    end
    abort_i = 1'b0;
    busy_n = n; idle_cyc = ncyc;
    if (busy_o) begin
      chk("finish_in_time", busy_o, 1'b0);
      do_reset();
    end
    chk("done", done_o, e_done);
    chk("err", err_o, e_err);
    if (e_err) begin
      chk("err_code", err_code_o, e_code);
      chk("err_index", err_index_o, e_idx);
    end
    if (tail_vld) chk("txn_cnt_tail", obs_cnt > n_exp, 1'b1);
    else          chk("txn_cnt", obs_cnt, n_exp);
    if (e_busy_vld) chk("busy_cycles", busy_n, e_busy);
    snap = cyc_total;
    repeat (20) @(negedge wb_clk_i);
    #1;
    chk("quiet_after", cyc_total, snap);
  endtask

  initial begin
    wb_rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    clear_tbl();
    repeat (3) @(negedge wb_clk_i);
    #1;
    cur_test = "reset";
    chk("busy", busy_o, 1'b0);
    chk("done", done_o, 1'b0);
    chk("err", err_o, 1'b0);
    chk("cyc", m_cyc_o, 1'b0);
    chk("tbl_addr", tbl_addr_o, 0);
    @(negedge wb_clk_i); wb_rst_i = 1'b0;

    // 1: two writes then END, fixed 3-cycle ack latency
    cur_test = "t1_writes";
    clear_tbl();
    set_ent(0, OP_WR, 18'h00004, 32'h1, 32'h0, 0, 0);
    set_ent(1, OP_WR, 18'h00008, 32'hDEADBEEF, 32'h0, 0, 0);
    set_ent(2, OP_END, 18'h0, 32'h0, 32'h0, 0, 0);
    lat_fix = 3;
    model_run();
    run_seq(2000);
    chk("ack_to_idle", idle_cyc - last_ack_cyc, 5);

    // 2: poll that matches on the third read
    cur_test = "t2_poll";
    clear_tbl();
    set_ent(0, OP_POLL, 18'h0200C, 32'h0000000E, 32'h0000000F, 2, 0);
    lat_fix = 1;
    model_run();
    rsp_q.delete();
    rsp_q.push_back(32'h0); rsp_q.push_back(32'h0); rsp_q.push_back(32'h1E);
    run_seq(2000);
    chk("reads", rd_cyc_q.size(), 3);
    if (rd_cyc_q.size() == 3) begin
      chk("gap01", (rd_cyc_q[1] - rd_cyc_q[0]) >= POLL_GAP + 1, 1'b1);
      chk("gap12", (rd_cyc_q[2] - rd_cyc_q[1]) >= POLL_GAP + 1, 1'b1);
    end

    // 3: poll never matches -> poll timeout at that entry
    cur_test = "t3_poll_tmo";
    clear_tbl();
    set_ent(0, OP_WR, 18'h00010, 32'h5, 32'h0, 0, 0);
    set_ent(1, OP_POLL, 18'h00020, 32'h5A, 32'hFF, 0, 1);
    lat_fix = 2;
    model_run();
    run_seq(3000);

    // 4: write at entry 5 never acked -> ack timeout after 2**TMO_BITS-1 cycles
    cur_test = "t4_ack_tmo";
    clear_tbl();
    for (int i = 0; i < 5; i++) set_ent(i, OP_WR, 18'(i * 4), 32'(i + 100), 32'h0, 0, 0);
    set_ent(5, OP_WR, NOACK, 32'h77, 32'h0, 0, 0);
    noack_on = 1; lat_fix = -1;
    model_run();
    run_seq(3000);
    chk("cyc_len", last_run, (1 << TMO_BITS) - 1);
    noack_on = 0;

    // 5: bridge error with the write ack at entry 2, then a clean rerun
    cur_test = "t5_bridge_err";
    clear_tbl();
    for (int i = 0; i < 4; i++) set_ent(i, OP_WR, 18'(16 + i), $urandom, 32'h0, 0, 0);
    berr_txn = 2;
    model_run();
    run_seq(2000);
    cur_test = "t5_rerun";
    berr_txn = -1;
    model_run();
    run_seq(2000);

    // create a sticky error so the reset check below has something to clear
    cur_test = "t5b_abort";
    clear_tbl();
    set_ent(0, OP_DLY, 18'h0, 32'd50, 32'h0, 0, 0);
    model_run();
    e_done = 0; e_err = 1; e_code = 3; e_idx = 0; e_busy_vld = 0;
    abort_at = 10;
    run_seq(2000);
    abort_at = -1;

    // 6: reset in the middle of a DELAY, then rerun
    cur_test = "t6_reset";
    clear_tbl();
    set_ent(0, OP_DLY, 18'h0, 32'hABCDEF00 | 32'd100, 32'h0, 0, 0);
    @(negedge wb_clk_i); start_i = 1'b1;
    @(negedge wb_clk_i); start_i = 1'b0;
    repeat (50) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0; #1;
    chk("busy", busy_o, 1'b0);
    chk("done", done_o, 1'b0);
    chk("err", err_o, 1'b0);
    chk("err_code", err_code_o, 2'd0);
    chk("err_index", err_index_o, 0);
    chk("cyc_stb_we", {m_cyc_o, m_stb_o, m_we_o}, 3'b000);
    cur_test = "t6_rerun";
    model_run();
    run_seq(2000);

    // 7: no END anywhere -> implicit end at the last index, no wrap
    cur_test = "t7_implicit_end";
    for (int i = 0; i < NENTRY; i++) set_ent(i, OP_DLY, 18'h0, 32'h0, 32'h0, 0, 0);
    model_run();
    run_seq(2000);
    chk("tbl_addr_last", tbl_addr_o, NENTRY - 1);

    // random tables
    for (int it = 0; it < 30; it++) begin
      int p;
      cur_test = $sformatf("rnd%0d", it);
      for (int i = 0; i < NENTRY; i++) begin
        p = $urandom_range(0, 99);
        tbl[i].op    = (p < 45) ? OP_WR : (p < 70) ? OP_POLL : (p < 90) ? OP_DLY : OP_END;
        tbl[i].adr   = 18'($urandom & 32'h0FFFF);
        tbl[i].dat   = $urandom;
        tbl[i].msk   = $urandom | 32'h1;
        tbl[i].nmiss = $urandom_range(0, 3);
        tbl[i].never = 0;
        if (tbl[i].op == OP_DLY) tbl[i].dat = ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 20));
      end
      berr_txn = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
      lat_fix = -1;
      model_run();
      run_seq(4000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
